// File: rtl/to_upper_pkg.sv
// Shared constants for the ASCII case converter: mode encodings, letter bounds
// and the position of the case bit.
package to_upper_pkg;

  typedef enum logic [1:0] {
    MODE_UPPER  = 2'b00,
    MODE_LOWER  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_PASS   = 2'b11
  } mode_e;

  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;

  localparam int CASE_BIT = 5;

endpackage

// File: rtl/to_upper_classify.sv
// Gate-level letter classifier: bits [7:5] select the upper/lower block and
// bits [4:0] must fall in 1..26 within that block.
module to_upper_classify (
  input  logic [7:0] x,
  output logic       is_upper,
  output logic       is_lower
);

  logic blk_upper;
  logic blk_lower;
  logic lo_nonzero;
  logic lo_above_26;
  logic lo_in_range;

  assign blk_upper = ~x[7] &  x[6] & ~x[5];
  assign blk_lower = ~x[7] &  x[6] &  x[5];

  // 27..31 are exactly the codes with x[4]&x[3] and either x[2] or x[1]&x[0].
  assign lo_nonzero  = |x[4:0];
  assign lo_above_26 = x[4] & x[3] & (x[2] | (x[1] & x[0]));
  assign lo_in_range = lo_nonzero & ~lo_above_26;

  assign is_upper = blk_upper & lo_in_range;
  assign is_lower = blk_lower & lo_in_range;

endmodule

// File: rtl/to_upper_core.sv
// Registered ASCII case converter with a saturating count of modified bytes.
// Only the case bit is ever flipped, and only for letters.
module to_upper_core
  import to_upper_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       x,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  output logic [7:0]       y,
  output logic             out_valid,
  output logic             is_letter,
  output logic [CNT_W-1:0] mod_count
);

  localparam logic [7:0] CASE_MASK = 8'h01 << CASE_BIT;

  logic  is_upper;
  logic  is_lower;
  logic  flip;
  mode_e mode_sel;
  logic  [7:0] y_next;

  to_upper_classify u_classify (
    .x        (x),
    .is_upper (is_upper),
    .is_lower (is_lower)
  );

  assign mode_sel = mode_e'(mode);

  always_comb begin
    flip = 1'b0;
    case (mode_sel)
      MODE_UPPER:  flip = is_lower;
      MODE_LOWER:  flip = is_upper;
      MODE_TOGGLE: flip = is_upper | is_lower;
      MODE_PASS:   flip = 1'b0;
      default:     flip = 1'b0;
    endcase
  end

  assign y_next = flip ? (x ^ CASE_MASK) : x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= 8'h00;
      out_valid <= 1'b0;
      is_letter <= 1'b0;
      mod_count <= '0;
    end else if (in_valid) begin
      y         <= y_next;
      out_valid <= 1'b1;
      is_letter <= is_upper | is_lower;
      if (flip && !(&mod_count))
        mod_count <= mod_count + 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_to_upper_core.sv
// Directed bench for to_upper_core: a vector table plus hand sequences for
// streaming, counter saturation, valid gaps and asynchronous reset.
module tb_to_upper_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  x;
  logic        in_valid;
  logic [1:0]  mode;
  logic [7:0]  y,  y4;
  logic        out_valid, out_valid4;
  logic        is_letter, is_letter4;
  logic [15:0] mod_count;
  logic [3:0]  mod_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  to_upper_core #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .mode(mode),
    .y(y), .out_valid(out_valid), .is_letter(is_letter), .mod_count(mod_count)
  );

  to_upper_core #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .mode(mode),
    .y(y4), .out_valid(out_valid4), .is_letter(is_letter4), .mod_count(mod_count4)
  );

  typedef struct {
    logic [7:0] x;
    logic [1:0] mode;
    logic [7:0] exp_y;
    logic       exp_letter;
    int         inc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive away from the active edge, then settle just after it.
  task automatic step(input logic [7:0] b, input logic v, input logic [1:0] m);
    @(negedge clk);
    x = b; in_valid = v; mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] bnd [7];
    logic [7:0] last_y;
    int exp_cnt;

    bnd[0] = 8'h40; bnd[1] = 8'h5B; bnd[2] = 8'h60; bnd[3] = 8'h7B;
    bnd[4] = 8'h00; bnd[5] = 8'hC1; bnd[6] = 8'hE1;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 7; i++)
        vecs.push_back('{bnd[i], 2'(m), bnd[i], 1'b0, 0});
    vecs.push_back('{8'h51, 2'b01, 8'h71, 1'b1, 1});
    vecs.push_back('{8'h71, 2'b10, 8'h51, 1'b1, 1});
    vecs.push_back('{8'h51, 2'b10, 8'h71, 1'b1, 1});
    vecs.push_back('{8'h61, 2'b11, 8'h61, 1'b1, 0});
    vecs.push_back('{8'h41, 2'b01, 8'h61, 1'b1, 1});
    vecs.push_back('{8'h5A, 2'b01, 8'h7A, 1'b1, 1});
    vecs.push_back('{8'h61, 2'b01, 8'h61, 1'b1, 0});
    vecs.push_back('{8'h41, 2'b00, 8'h41, 1'b1, 0});
    vecs.push_back('{8'h1A, 2'b10, 8'h1A, 1'b0, 0});
    vecs.push_back('{8'h5F, 2'b10, 8'h5F, 1'b0, 0});
    vecs.push_back('{8'h7F, 2'b00, 8'h7F, 1'b0, 0});
    vecs.push_back('{8'h3A, 2'b01, 8'h3A, 1'b0, 0});

    rst = 1'b1; x = 8'h00; in_valid = 1'b0; mode = 2'b00;
    #12;
    chk("reset_y",         y,          8'h00);
    chk("reset_out_valid", out_valid,  1'b0);
    chk("reset_is_letter", is_letter,  1'b0);
    chk("reset_count",     mod_count,  0);
    chk("reset_count4",    mod_count4, 0);
    @(negedge clk);
    rst = 1'b0;

    // a..z to upper; the 4-bit counter must pin at 15
    for (int i = 0; i < 26; i++) begin
      step(8'h61 + 8'(i), 1'b1, 2'b00);
      chk("lower_stream_y",         y,         8'h41 + 8'(i));
      chk("lower_stream_out_valid", out_valid, 1'b1);
      chk("lower_stream_is_letter", is_letter, 1'b1);
      chk("lower_stream_count",     mod_count, i + 1);
      chk("lower_stream_count4",    mod_count4, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("count_after_az", mod_count, 26);

    // gap: out_valid drops, y and counters hold
    step(8'h62, 1'b0, 2'b00);
    chk("gap_out_valid", out_valid, 1'b0);
    chk("gap_y_hold",    y,         8'h5A);
    chk("gap_letter",    is_letter, 1'b1);
    chk("gap_count",     mod_count, 26);
    chk("gap_count4",    mod_count4, 4'hF);

    // asynchronous reset between edges, mid-stream
    step(8'h63, 1'b1, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y",         y,          8'h00);
    chk("async_rst_out_valid", out_valid,  1'b0);
    chk("async_rst_letter",    is_letter,  1'b0);
    chk("async_rst_count",     mod_count,  0);
    chk("async_rst_count4",    mod_count4, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    step(8'h7A, 1'b1, 2'b00);
    chk("post_rst_y",         y,         8'h5A);
    chk("post_rst_out_valid", out_valid, 1'b1);
    chk("post_rst_count",     mod_count, 1);

    // A..Z in mode 00 leaves everything unchanged
    do_reset();
    for (int i = 0; i < 26; i++) begin
      step(8'h41 + 8'(i), 1'b1, 2'b00);
      chk("upper_stream_y",      y,         8'h41 + 8'(i));
      chk("upper_stream_letter", is_letter, 1'b1);
      chk("upper_stream_count",  mod_count, 0);
    end

    // table vectors, running expected count
    do_reset();
    exp_cnt = 0;
    foreach (vecs[k]) begin
      step(vecs[k].x, 1'b1, vecs[k].mode);
      exp_cnt += vecs[k].inc;
      chk($sformatf("vec%0d_y", k),         y,         vecs[k].exp_y);
      chk($sformatf("vec%0d_letter", k),    is_letter, vecs[k].exp_letter);
      chk($sformatf("vec%0d_out_valid", k), out_valid, 1'b1);
      chk($sformatf("vec%0d_count", k),     mod_count, exp_cnt);
    end

    // mode change applies to the very next byte, across a gap
    last_y = y;
    step(8'h41, 1'b0, 2'b01);
    chk("gap2_out_valid", out_valid, 1'b0);
    chk("gap2_y_hold",    y,         last_y);
    step(8'h41, 1'b1, 2'b01);
    chk("modechg_y_lower", y, 8'h61);
    step(8'h61, 1'b1, 2'b00);
    chk("modechg_y_upper", y, 8'h41);
    chk("modechg_count",   mod_count, exp_cnt + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
